// File: rtl/cnn_mac_pkg.sv
// Shared widths, state encoding and parameter sanity helper for the conv2 MAC sequencer.
package cnn_mac_pkg;

  localparam int A_W   = 9;   // activation width (signed)
  localparam int B_W   = 14;  // weight width (signed)
  localparam int P_W   = 23;  // full-precision product width
  localparam int ACC_W = 32;  // accumulator / result width (signed)
  localparam int LEN_W = 16;  // operand-pair count width

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // Product must be exact and must fit inside the accumulator without truncation.
  function automatic bit widths_ok(input int a_w, input int b_w, input int p_w, input int acc_w);
    return (p_w == a_w + b_w) && (acc_w >= p_w);
  endfunction

endpackage

// File: rtl/cnn_mac_mul_9s_14s.sv
// Combinational signed 9x14 multiplier; small enough to map onto a single DSP slice.
module cnn_mac_mul_9s_14s
  import cnn_mac_pkg::*;
(
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  // Both operands are sign-extended to the product width, so the result is exact.
  assign p = P_W'(a) * P_W'(b);

endmodule

// File: rtl/cnn_mac_seq_9s_14s.sv
// Dot-product sequencer for one conv2 output pixel: start/len control, one operand
// pair per cycle, a single product pipeline register and a wrapping accumulator.
module cnn_mac_seq_9s_14s
  import cnn_mac_pkg::*;
#(
  parameter int ACC_W = cnn_mac_pkg::ACC_W
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  input  logic [LEN_W-1:0]        len,
  output logic                    ap_idle,
  output logic                    ap_done,
  output logic                    ap_ready,
  input  logic signed [A_W-1:0]   op_a,
  input  logic signed [B_W-1:0]   op_b,
  input  logic                    op_valid,
  output logic                    op_ready,
  output logic signed [ACC_W-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready
);

  if (!widths_ok(A_W, B_W, P_W, ACC_W)) begin : g_width_check
    $error("cnn_mac_seq_9s_14s: need P_W == A_W+B_W and ACC_W >= P_W");
  end

  state_t                  state;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt;
  logic signed [P_W-1:0]   p_comb;
  logic signed [P_W-1:0]   p_q;
  logic                    p_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    accept;
  logic                    last;

  cnn_mac_mul_9s_14s u_mul (
    .a (op_a),
    .b (op_b),
    .p (p_comb)
  );

  // op_ready is a registered copy of "state == RUN", so it alone qualifies the handshake.
  assign accept   = (state == RUN) && op_valid && op_ready;
  assign last     = accept && (LEN_W'(cnt + LEN_W'(1)) == len_q);
  // Sign-extended product add; overflow wraps modulo 2^ACC_W by design.
  assign acc_next = p_vld ? ACC_W'(acc + ACC_W'(p_q)) : acc;

  // Sequencer FSM with product pipeline, accumulator and registered handshake outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      p_q       <= '0;
      p_vld     <= 1'b0;
      acc       <= '0;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b0;
      op_ready  <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      acc      <= acc_next;
      p_vld    <= accept;
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      if (accept) begin
        p_q <= p_comb;
        cnt <= LEN_W'(cnt + LEN_W'(1));
      end
      case (state)
        IDLE: begin
          if (ap_start) begin
            acc     <= '0;
            ap_idle <= 1'b0;
            if (len != '0) begin
              len_q    <= len;
              cnt      <= '0;
              op_ready <= 1'b1;
              state    <= RUN;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        RUN: begin
          if (last) begin
            op_ready <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          // The final product lands this edge, so publish the post-add value.
          res_data  <= acc_next;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ap_done   <= 1'b1;
            ap_ready  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          ap_idle <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ap_idle   <= 1'b1;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mac_seq_9s_14s.sv
// Directed testbench for the conv2 MAC sequencer: a 32-bit accumulator instance plus
// a 23-bit accumulator instance (driven by the same inputs) for the wrap-around case.
module tb_cnn_mac_seq_9s_14s;

  logic               ap_clk;
  logic               ap_rst;
  logic               ap_start;
  logic [15:0]        len;
  logic signed [8:0]  op_a;
  logic signed [13:0] op_b;
  logic               op_valid;
  logic               res_ready;

  logic               ap_idle, ap_done, ap_ready, op_ready, res_valid;
  logic signed [31:0] res_data;
  logic               ap_idle_w, ap_done_w, ap_ready_w, op_ready_w, res_valid_w;
  logic signed [22:0] res_data_w;

  int n_checks;
  int n_fail;
  int done_cnt;

  cnn_mac_seq_9s_14s dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .len       (len),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .ap_ready  (ap_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  cnn_mac_seq_9s_14s #(.ACC_W(23)) dut_w (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .len       (len),
    .ap_idle   (ap_idle_w),
    .ap_done   (ap_done_w),
    .ap_ready  (ap_ready_w),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready_w),
    .res_data  (res_data_w),
    .res_valid (res_valid_w),
    .res_ready (res_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Count every cycle ap_done is high, sampled mid-cycle.
  always @(negedge ap_clk) if (ap_done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] n);
    ap_start = 1'b1;
    len      = n;
    step();
    ap_start = 1'b0;
    len      = '0;
  endtask

  task automatic send_pair(input int a, input int b);
    int waited;
    op_a     = 9'(a);
    op_b     = 14'(b);
    op_valid = 1'b1;
    waited   = 0;
    while (op_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (op_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_pair: op_ready never rose for pair (%0d,%0d)", a, b);
    end else begin
      step();
    end
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    int d0;
    ap_rst = 1'b1;
    step();
    step();
    d0 = done_cnt;
    ap_rst = 1'b0;
    step();
    step();
    n_checks++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, expected 1", ap_idle); end
    n_checks++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready: got %b, expected 0", op_ready); end
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b, expected 0", res_valid); end
    n_checks++;
    if (res_data !== 32'sd0) begin n_fail++; $display("FAIL reset_res_data: got %0d, expected 0", res_data); end
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses, expected 0", done_cnt - d0); end
    $display("reset: idle=%b op_ready=%b res_valid=%b", ap_idle, op_ready, res_valid);
  endtask

  task automatic test_signed_extremes();
    int d0;
    d0 = done_cnt;
    res_ready = 1'b1;
    start_op(16'd3);
    send_pair(2, 100);
    send_pair(-3, 50);
    send_pair(-256, -8192);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL signed_drain_valid: got %b, expected 0", res_valid); end
    step();
    n_checks++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL signed_res_valid: got %b, expected 1", res_valid); end
    n_checks++;
    if (res_data !== 32'sd2097202) begin n_fail++; $display("FAIL signed_res_data: got %0d, expected 2097202", res_data); end
    step();
    n_checks++;
    if (ap_done !== 1'b1 || ap_ready !== 1'b1) begin
      n_fail++; $display("FAIL signed_done: got done=%b ready=%b, expected 1/1", ap_done, ap_ready);
    end
    step();
    n_checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      n_fail++; $display("FAIL signed_idle: got idle=%b done=%b, expected 1/0", ap_idle, ap_done);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL signed_done_count: got %0d, expected 1", done_cnt - d0); end
    $display("signed_extremes: res=%0d", res_data);
  endtask

  task automatic test_stalls();
    int d0;
    d0 = done_cnt;
    res_ready = 1'b0;
    start_op(16'd4);
    send_pair(255, 8191);
    send_pair(255, 8191);
    // 3-cycle gap; ap_start pulsed with a different length must be ignored
    ap_start = 1'b1;
    len      = 16'd7;
    step();
    ap_start = 1'b0;
    len      = '0;
    step();
    step();
    send_pair(255, 8191);
    step();
    send_pair(255, 8191);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 32'sd8354820 || ap_done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%0d done=%b, expected 1/8354820/0",
                 i, res_valid, res_data, ap_done);
      end
    end
    res_ready = 1'b1;
    step();
    n_checks++;
    if (ap_done !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_done: got done=%b valid=%b, expected 1/0", ap_done, res_valid);
    end
    step();
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d, expected 1", done_cnt - d0); end
    $display("stalls: res=%0d", res_data);
  endtask

  task automatic test_zero_len();
    res_ready = 1'b0;
    start_op(16'd0);
    n_checks++;
    if (op_ready !== 1'b0) begin n_fail++; $display("FAIL zero_op_ready: got %b, expected 0", op_ready); end
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'sd0) begin
      n_fail++; $display("FAIL zero_result: got valid=%b data=%0d, expected 1/0", res_valid, res_data);
    end
    res_ready = 1'b1;
    step();
    n_checks++;
    if (ap_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, expected 1", ap_done); end
    step();
    n_checks++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL zero_idle: got %b, expected 1", ap_idle); end
    $display("zero_len: res=%0d", res_data);
  endtask

  task automatic test_wrap();
    res_ready = 1'b1;
    start_op(16'd2);
    send_pair(-256, -8192);
    send_pair(-256, -8192);
    step();
    n_checks++;
    if (res_data !== 32'sd4194304) begin n_fail++; $display("FAIL wrap_acc32: got %0d, expected 4194304", res_data); end
    n_checks++;
    if (res_valid_w !== 1'b1 || res_data_w !== 23'h400000) begin
      n_fail++; $display("FAIL wrap_acc23: got valid=%b data=%0d, expected 1/-4194304", res_valid_w, res_data_w);
    end
    step();
    step();
    $display("wrap: acc32=%0d acc23=%0d", res_data, res_data_w);
  endtask

  task automatic test_reset_mid();
    int d0;
    res_ready = 1'b1;
    start_op(16'd5);
    send_pair(100, 1000);
    send_pair(50, 2000);
    ap_rst = 1'b1;
    #1;
    n_checks++;
    if (ap_idle !== 1'b1 || op_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: got idle=%b op_ready=%b, expected 1/0", ap_idle, op_ready);
    end
    step();
    d0 = done_cnt;
    ap_rst = 1'b0;
    step();
    n_checks++;
    if (done_cnt != d0 || ap_idle !== 1'b1) begin
      n_fail++; $display("FAIL midreset_release: got done pulses=%0d idle=%b, expected 0/1", done_cnt - d0, ap_idle);
    end
    start_op(16'd1);
    send_pair(1, 1);
    step();
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 32'sd1) begin
      n_fail++; $display("FAIL midreset_result: got valid=%b data=%0d, expected 1/1", res_valid, res_data);
    end
    step();
    step();
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL midreset_done_count: got %0d, expected 1", done_cnt - d0); end
    $display("reset_mid: res=%0d", res_data);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_cnt  = 0;
    ap_rst    = 1'b1;
    ap_start  = 1'b0;
    len       = '0;
    op_a      = '0;
    op_b      = '0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_signed_extremes();
    test_stalls();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
